seq_shift_add_multiplier: RTL and testbench
===========================================

Name: seq_shift_add_multiplier

Overview:
- Multi-cycle, parametrised shift-and-add multiplier for the calculator datapath.
- Replaces the fully combinational 4x4 multiply with a one-partial-product-per-clock engine.
- Supports signed and unsigned modes and a start/busy/done handshake.
- Sits between the operand/memory registers and the result mux; the control FSM issues start and waits for done.

Parameters:
- WIDTH, 4, operand width in bits (legal 2..16).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a multiply; honoured only in IDLE.
- signedMode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- operand1  input  WIDTH  multiplicand; sampled with start.
- operand2  input  WIDTH  multiplier; sampled with start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse when product is valid.
- product  output  2*WIDTH  result; holds its value until the next done.

Behaviour:
- Reset: one clock, one asynchronous active-low reset. On rst_n low, immediately: state=IDLE, busy=0, done=0, product=0, all internal registers=0.
- States:
  - IDLE: busy=0. If start=1, register the operands and signedMode, counter=0, go to RUN.
  - RUN: busy=1, one iteration per cycle.
  - FIN: busy=1, product loaded; next state IDLE with done=1 for that single cycle.
- Accept (IDLE & start):
  - Latch mcand = |operand1| zero-extended to 2*WIDTH, and mplier = |operand2|.
  - Absolute value is taken only if signedMode=1 and the MSB is 1; otherwise the raw value is used.
  - neg = signedMode & (operand1[MSB] ^ operand2[MSB]); acc = 0.
- RUN iteration:
  - If mplier[0], acc += mcand (2*WIDTH wide, no carry out possible).
  - mcand <<= 1; mplier >>= 1; counter++.
  - After the WIDTH-th iteration (counter == WIDTH-1 at the clock edge), go to FIN.
- FIN: product <= neg ? -acc : acc (2*WIDTH two's complement).
- Latency, fixed and data-independent: start sampled at edge 0, busy=1 after edge 0, done=1 and product valid after edge WIDTH+1. For WIDTH=4, done appears 5 cycles after start.
- Most-negative operand: the absolute value of -2^(WIDTH-1) is 2^(WIDTH-1) in WIDTH bits unsigned, which is correct. All signed results fit in 2*WIDTH bits, e.g. -8*-8 = +64 = 0x40 for WIDTH=4.
- start while busy (RUN/FIN): ignored, no queueing; the operand inputs may change freely.
- start on the same cycle done is high (state returns to IDLE): accepted. This allows back-to-back operations with a WIDTH+2 cycle period.
- Reset mid-operation: aborts immediately. No done pulse; product is cleared to 0.
- Zero operand: still takes the full WIDTH iterations; product = 0, and neg is ignored since -0 = 0.
- product does not change except in the FIN cycle or on reset.

Test Plan:
- Unsigned, WIDTH=4: operand1=15, operand2=15, start one cycle -> busy for 5 cycles, done pulses once 5 cycles after start, product=0xE1 (225).
- Signed, WIDTH=4: operand1=4'b1000 (-8), operand2=4'b1000 (-8) -> product=0x40. Then operand1=4'b1101 (-3), operand2=5 -> product=0xF1 (-15).
- Handshake: start again 2 cycles into an op with 3*3 -> ignored, first result (7*6=0x2A) is unchanged. Start asserted in the done cycle with 2*3 -> accepted, product=0x06 after 5 more cycles.
- Reset mid-op: start 9*9, pull rst_n low for 1 ns asynchronously at cycle 2 -> busy=0, done=0, product=0 without waiting for a clock; no done pulse follows.
- Zero and hold: 0*13 unsigned -> product=0x00 with full latency. Afterwards, wiggle the operands with no start for 10 cycles -> product stays 0x00 and done stays 0.
- WIDTH=8 build: signed -128*127 -> product=16'hC080 (-16256), done 9 cycles after start. Unsigned 255*255 -> 16'hFE01.

Source files
------------

// File: rtl/seq_shift_add_multiplier.sv
// Multi-cycle shift-and-add multiplier, one partial product per clock.
// Ports: clk, rst_n, start/signedMode/operand1/operand2 in; busy/done/product out.
module seq_shift_add_multiplier #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signedMode,
  input  logic [WIDTH-1:0]     operand1,
  input  logic [WIDTH-1:0]     operand2,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t               state_q;
  state_t               state_d;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 neg_q;
  logic                 done_q;
  logic [2*WIDTH-1:0]   prod_q;

  logic                 neg1;
  logic                 neg2;
  logic [WIDTH-1:0]     abs1;
  logic [WIDTH-1:0]     abs2;

  // -(-2^(W-1)) wraps to 2^(W-1), which is the right magnitude unsigned
  assign neg1 = signedMode & operand1[WIDTH-1];
  assign neg2 = signedMode & operand2[WIDTH-1];
  assign abs1 = neg1 ? -operand1 : operand1;
  assign abs2 = neg2 ? -operand2 : operand2;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == LAST) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
      prod_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            mcand_q  <= {{WIDTH{1'b0}}, abs1};
            mplier_q <= abs2;
            neg_q    <= neg1 ^ neg2;
            acc_q    <= '0;
            cnt_q    <= '0;
          end
        end
        RUN: begin
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + ONE;
        end
        FIN: begin
          prod_q <= neg_q ? -acc_q : acc_q;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign product = prod_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Bench for seq_shift_add_multiplier: WIDTH=4 scoreboard plus a WIDTH=8 build.
// Ports of both instances are driven from here.
module tb_seq_shift_add_multiplier;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       sm = 1'b0;
  logic [3:0] op1 = '0;
  logic [3:0] op2 = '0;
  logic       busy;
  logic       done;
  logic [7:0] prod;

  logic        start8 = 1'b0;
  logic        sm8 = 1'b0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        busy8;
  logic        done8;
  logic [15:0] prod8;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] exp;
    int         at;
  } sb_t;
  sb_t q[$];

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       s;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[8];

  seq_shift_add_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .signedMode(sm), .operand1(op1), .operand2(op2),
    .busy(busy), .done(done), .product(prod)
  );

  seq_shift_add_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8),
    .signedMode(sm8), .operand1(a8), .operand2(b8),
    .busy(busy8), .done(done8), .product(prod8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        sb_t e;
        e = q.pop_front();
        chk("sb_product", 32'(prod), 32'(e.exp));
        chk("sb_latency", 32'(cyc), 32'(e.at));
        chk("busy_in_done", 32'(busy), 32'd0);
      end
    end
  end

  task automatic issue(logic [3:0] a, logic [3:0] b, logic s,
                       logic [7:0] exp, bit push);
    sb_t e;
    op1 = a;
    op2 = b;
    sm = s;
    start = 1'b1;
    if (push) begin
      e.exp = exp;
      e.at = cyc + 6;
      q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    op1 = $urandom();
    op2 = $urandom();
    sm = $urandom();
  endtask

  task automatic wait_done(output int nbusy);
    nbusy = busy ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) return;
      if (busy) nbusy++;
    end
    chk("done_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    int nb;
    int seen;
    int n;

    tbl[0] = '{4'd15, 4'd15, 1'b0, 8'hE1};
    tbl[1] = '{4'b1000, 4'b1000, 1'b1, 8'h40};
    tbl[2] = '{4'b1101, 4'd5, 1'b1, 8'hF1};
    tbl[3] = '{4'd7, 4'b1000, 1'b1, 8'hC8};
    tbl[4] = '{4'b1000, 4'b1111, 1'b1, 8'h08};
    tbl[5] = '{4'b1111, 4'b1111, 1'b1, 8'h01};
    tbl[6] = '{4'd10, 4'd3, 1'b0, 8'h1E};
    tbl[7] = '{4'd8, 4'd15, 1'b0, 8'h78};

    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_prod", 32'(prod), 32'd0);
    chk("rst_prod8", 32'(prod8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      issue(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].exp, 1'b1);
      wait_done(nb);
      chk("busy_cycles", 32'(nb), 32'd5);
      @(negedge clk);
      chk("done_pulse", 32'(done), 32'd0);
    end

    issue(4'd7, 4'd6, 1'b0, 8'h2A, 1'b1);
    op1 = 4'd3;
    op2 = 4'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(nb);
    issue(4'd2, 4'd3, 1'b0, 8'h06, 1'b1);
    wait_done(nb);
    chk("b2b_busy", 32'(nb), 32'd5);
    @(negedge clk);

    issue(4'd9, 4'd9, 1'b0, 8'h00, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_prod", 32'(prod), 32'd0);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("abort_no_done", 32'(seen), 32'd0);

    issue(4'd0, 4'd13, 1'b0, 8'h00, 1'b1);
    wait_done(nb);
    chk("zero_busy", 32'(nb), 32'd5);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      op1 = $urandom();
      op2 = $urandom();
      sm = $urandom();
      @(negedge clk);
      if (done || prod != 8'h00) seen++;
    end
    chk("hold_quiet", 32'(seen), 32'd0);
    chk("sb_empty", 32'(q.size()), 32'd0);

    a8 = 8'h80;
    b8 = 8'd127;
    sm8 = 1'b1;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    n = 0;
    while (!done8 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("w8_latency", 32'(n), 32'd9);
    chk("w8_signed", 32'(prod8), 32'hC080);

    @(negedge clk);
    a8 = 8'd255;
    b8 = 8'd255;
    sm8 = 1'b0;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    n = 0;
    while (!done8 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("w8_lat_u", 32'(n), 32'd9);
    chk("w8_unsigned", 32'(prod8), 32'hFE01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
